// File: rtl/dice_game_ctrl_if.sv
// Player/die/display bundle for dice_game_ctrl.
//   button          : asynchronous player button, active-high
//   value_a/value_b : die faces, valid 1..6
//   roll            : roll strobe to both die instances
//   sum/point       : last evaluated sum, current point (0 = none)
//   win/lose        : game result flags
//   err             : one-cycle pulse, invalid face sampled
//   busy            : throw in progress (roll, settle, evaluate)
// master = the controller, slave = board/dice/display side.
interface dice_game_ctrl_if;
  logic       button;
  logic [3:0] value_a;
  logic [3:0] value_b;
  logic       roll;
  logic [3:0] sum;
  logic [3:0] point;
  logic       win;
  logic       lose;
  logic       err;
  logic       busy;

  modport master (
    input  button, value_a, value_b,
    output roll, sum, point, win, lose, err, busy
  );

  modport slave (
    output button, value_a, value_b,
    input  roll, sum, point, win, lose, err, busy
  );
endinterface

// File: rtl/dice_game_ctrl.sv
// Craps-style game sequencer for two die instances.
// A synchronised button press starts a throw: roll is held high for at least MIN_ROLL cycles
// (longer while the button is held), then low for SETTLE_CYCLES, then both faces are sampled,
// summed and scored by come-out / point-phase rules.
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   bus          : dice_game_ctrl_if.master (button, faces in; roll, sum, point, flags out)
//   roll_count_o : completed evaluations since reset, saturating (only with ROLL_COUNT_EN)
// Build option: define ROLL_COUNT_EN to add the roll_count_o port and its counter.
module dice_game_ctrl #(
  parameter int unsigned MIN_ROLL      = 16,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dice_game_ctrl_if.master bus
`ifdef ROLL_COUNT_EN
  ,
  output logic [7:0]       roll_count_o
`endif
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRoll   = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StEval   = 3'd3;
  localparam logic [2:0] StPoint  = 3'd4;
  localparam logic [2:0] StWin    = 3'd5;
  localparam logic [2:0] StLose   = 3'd6;

  // One counter serves both ROLL and SETTLE; it only ever needs to reach max-1.
  localparam int unsigned CntMax = (MIN_ROLL > SETTLE_CYCLES) ? MIN_ROLL : SETTLE_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] RollLast   = CntW'(MIN_ROLL - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      sync_q;
  logic            btn_dly_q;
  logic [3:0]      sum_q, sum_d;
  logic [3:0]      point_q, point_d;
  logic            err_q, err_d;

  logic       btn_s;
  logic       press;
  logic       face_ok;
  logic [4:0] sum5;

  assign btn_s   = sync_q[1];
  assign press   = btn_s & ~btn_dly_q;
  assign face_ok = (bus.value_a != 4'd0) && (bus.value_a <= 4'd6) &&
                   (bus.value_b != 4'd0) && (bus.value_b <= 4'd6);
  assign sum5    = {1'b0, bus.value_a} + {1'b0, bus.value_b};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    point_d = point_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle, StWin, StLose: begin
        if (press) begin
          state_d = StRoll;
          cnt_d   = '0;
          point_d = 4'd0;  // new game: come-out roll
        end
      end
      StPoint: begin
        if (press) begin
          state_d = StRoll;
          cnt_d   = '0;
        end
      end
      StRoll: begin
        if (cnt_q >= RollLast && !btn_s) begin
          state_d = StSettle;
          cnt_d   = '0;
        end else if (cnt_q < RollLast) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          state_d = StEval;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StEval: begin
        if (!face_ok) begin
          err_d   = 1'b1;
          state_d = (point_q == 4'd0) ? StIdle : StPoint;
        end else begin
          sum_d = sum5[3:0];
          if (point_q == 4'd0) begin
            if (sum5 == 5'd7 || sum5 == 5'd11) begin
              state_d = StWin;
            end else if (sum5 == 5'd2 || sum5 == 5'd3 || sum5 == 5'd12) begin
              state_d = StLose;
            end else begin
              point_d = sum5[3:0];
              state_d = StPoint;
            end
          end else if (sum5[3:0] == point_q) begin
            state_d = StWin;
          end else if (sum5 == 5'd7) begin
            state_d = StLose;
          end else begin
            state_d = StPoint;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sync_q    <= 2'b00;
      btn_dly_q <= 1'b0;
      sum_q     <= 4'd0;
      point_q   <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync_q    <= {sync_q[0], bus.button};
      btn_dly_q <= btn_s;
      sum_q     <= sum_d;
      point_q   <= point_d;
      err_q     <= err_d;
    end
  end

  // win/lose are decoded from registered state, so they change on the EVAL exit edge.
  assign bus.roll  = (state_q == StRoll);
  assign bus.busy  = (state_q == StRoll) || (state_q == StSettle) || (state_q == StEval);
  assign bus.win   = (state_q == StWin);
  assign bus.lose  = (state_q == StLose);
  assign bus.sum   = sum_q;
  assign bus.point = point_q;
  assign bus.err   = err_q;

`ifdef ROLL_COUNT_EN
  logic [7:0] rc_q;

  // Counts every evaluation, valid or not; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rc_q <= 8'd0;
    end else if (state_q == StEval && rc_q != 8'hFF) begin
      rc_q <= rc_q + 8'd1;
    end
  end

  assign roll_count_o = rc_q;
`endif

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Bench for dice_game_ctrl: directed throws scored by a timeline/rules model, checked every
// cycle, plus literal expectations after each scenario.
module tb_dice_game_ctrl;
  localparam int MinRoll = 16;
  localparam int Settle  = 4;

  logic clk = 1'b0;
  logic rst;
  dice_game_ctrl_if bus ();
`ifdef ROLL_COUNT_EN
  logic [7:0] roll_count;
`endif

  dice_game_ctrl #(
    .MIN_ROLL     (MinRoll),
    .SETTLE_CYCLES(Settle)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus)
`ifdef ROLL_COUNT_EN
    ,
    .roll_count_o(roll_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Settled game state between throws.
  int m_sum = 0, m_point = 0, m_rc = 0;
  bit m_win = 1'b0, m_lose = 1'b0;
  // Timeline of the throw in flight (cycle = number of rising edges seen).
  bit thr_act = 1'b0;
  int t_start, n_roll, t_done, rst_cyc, mid_point;
  int nw_sum, nw_point, nw_rc;
  bit nw_win, nw_lose, nw_err;
  int roll_hi_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  task automatic cmp_outputs();
    int e_sum = m_sum, e_point = m_point, e_rc = m_rc;
    int e_win = m_win, e_lose = m_lose, e_roll = 0, e_busy = 0, e_err = 0;
    if (thr_act) begin
      if (cyc >= rst_cyc) begin
        e_sum = 0; e_point = 0; e_win = 0; e_lose = 0; e_rc = 0;
      end else if (cyc >= t_done) begin
        e_sum = nw_sum; e_point = nw_point; e_win = nw_win; e_lose = nw_lose;
        e_err = (nw_err && cyc == t_done) ? 1 : 0;
        e_rc  = nw_rc;
      end else if (cyc >= t_start) begin
        e_roll = (cyc < t_start + n_roll) ? 1 : 0;
        e_busy = 1; e_point = mid_point; e_win = 0; e_lose = 0;
      end
    end
    check("roll", int'(bus.roll), e_roll);
    check("busy", int'(bus.busy), e_busy);
    check("err", int'(bus.err), e_err);
    check("sum", int'(bus.sum), e_sum);
    check("point", int'(bus.point), e_point);
    check("win", int'(bus.win), e_win);
    check("lose", int'(bus.lose), e_lose);
`ifdef ROLL_COUNT_EN
    check("roll_count", int'(roll_count), e_rc);
`endif
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (chk_en) cmp_outputs();
      if (bus.roll) roll_hi_cnt++;
    end
  end

  // Raise the button at a falling edge and derive the whole throw from the game rules.
  task automatic start_throw(input int hold, input int a, input int b);
    int p, s;
    @(negedge clk);
    bus.value_a = 4'(a);
    bus.value_b = 4'(b);
    bus.button  = 1'b1;
    roll_hi_cnt = 0;
    p         = cyc;
    mid_point = (m_win || m_lose) ? 0 : m_point;
    n_roll    = (hold > MinRoll) ? hold : MinRoll;
    t_start   = p + 3;
    t_done    = t_start + n_roll + Settle + 1;
    rst_cyc   = 32'h7fff_ffff;
    nw_rc     = (m_rc == 255) ? 255 : m_rc + 1;
    nw_sum = m_sum; nw_point = mid_point; nw_win = 0; nw_lose = 0; nw_err = 0;
    if (a < 1 || a > 6 || b < 1 || b > 6) begin
      nw_err = 1;
    end else begin
      s = a + b;
      nw_sum = s;
      if (mid_point == 0) begin
        if (s == 7 || s == 11) nw_win = 1;
        else if (s == 2 || s == 3 || s == 12) nw_lose = 1;
        else nw_point = s;
      end else if (s == mid_point) nw_win = 1;
      else if (s == 7) nw_lose = 1;
    end
    thr_act = 1'b1;
  endtask

  task automatic finish_throw();
    while (cyc < t_done + 1) @(negedge clk);
    m_sum = nw_sum; m_point = nw_point; m_win = nw_win; m_lose = nw_lose; m_rc = nw_rc;
    thr_act = 1'b0;
  endtask

  task automatic throw(input int hold, input int a, input int b);
    start_throw(hold, a, b);
    repeat (hold) @(negedge clk);
    bus.button = 1'b0;
    finish_throw();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.button  = 1'b0;
    bus.value_a = 4'd1;
    bus.value_b = 4'd1;
    repeat (2) @(negedge clk);
    check("rst roll", int'(bus.roll), 0);
    check("rst sum", int'(bus.sum), 0);
    check("rst point", int'(bus.point), 0);
    check("rst win", int'(bus.win), 0);
    check("rst lose", int'(bus.lose), 0);
    check("rst err", int'(bus.err), 0);
    check("rst busy", int'(bus.busy), 0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Natural 7 on come-out.
    throw(2, 3, 4);
    check("t2 roll len", roll_hi_cnt, 16);
    check("t2 sum", int'(bus.sum), 7);
    check("t2 win", int'(bus.win), 1);

    // Craps 3, then a new game clears lose and goes busy.
    throw(2, 1, 2);
    check("t3 sum", int'(bus.sum), 3);
    check("t3 lose", int'(bus.lose), 1);
    check("t3 point", int'(bus.point), 0);
    start_throw(2, 2, 4);
    repeat (2) @(negedge clk);
    bus.button = 1'b0;
    while (cyc < t_start) @(negedge clk);
    check("t3 lose cleared", int'(bus.lose), 0);
    check("t3 busy", int'(bus.busy), 1);
    finish_throw();
    check("t4 point", int'(bus.point), 6);
    throw(2, 5, 5);
    check("t4 sum 10", int'(bus.sum), 10);
    check("t4 point kept", int'(bus.point), 6);
    check("t4 no win", int'(bus.win), 0);
    throw(2, 3, 3);
    check("t4 win", int'(bus.win), 1);

    // Point 8, seven-out, then a long held roll.
    throw(2, 4, 4);
    check("t5 point", int'(bus.point), 8);
    throw(2, 6, 1);
    check("t5 lose", int'(bus.lose), 1);
    throw(40, 2, 5);
    check("t5 roll len", roll_hi_cnt, 40);
    check("t5 win", int'(bus.win), 1);

    // Invalid faces: come-out and point phase.
    throw(2, 0, 7);
    check("t6 sum kept", int'(bus.sum), 7);
    check("t6 point", int'(bus.point), 0);
    throw(2, 2, 2);
    throw(2, 9, 1);
    check("t6 point kept", int'(bus.point), 4);
    throw(2, 1, 3);
    check("t6 point win", int'(bus.win), 1);

    // Button pulse during SETTLE must not start another throw.
    start_throw(2, 5, 6);
    repeat (2) @(negedge clk);
    bus.button = 1'b0;
    while (cyc < t_start + n_roll) @(negedge clk);
    bus.button = 1'b1;
    @(negedge clk);
    bus.button = 1'b0;
    finish_throw();
    repeat (6) @(negedge clk);
    check("settle press ignored", int'(bus.busy), 0);
    check("settle win", int'(bus.win), 1);

    // Reset in the middle of a roll.
    start_throw(2, 3, 4);
    repeat (2) @(negedge clk);
    bus.button = 1'b0;
    while (cyc < t_start + 5) @(negedge clk);
    check("roll before rst", int'(bus.roll), 1);
    rst     = 1'b1;
    rst_cyc = cyc + 1;
    @(negedge clk);
    check("roll after rst", int'(bus.roll), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    thr_act = 1'b0;
    m_sum = 0; m_point = 0; m_win = 0; m_lose = 0; m_rc = 0;
    check("no eval after rst", int'(bus.sum), 0);

`ifdef ROLL_COUNT_EN
    throw(2, 1, 1);
    check("rc first", int'(roll_count), 1);
    for (int i = 0; i < 256; i++) throw(2, 1, 1);
    check("rc saturate", int'(roll_count), 255);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
